// File: rtl/fir_tdm_mac_filter_pkg.sv
// rtl/fir_tdm_mac_filter_pkg.sv - shared FSM type and arithmetic helpers for the TDM serial-MAC FIR
package fir_pkg;

   localparam int SAT_W = 64;

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_e;

   function automatic int fir_acc_w(input int dw, input int cw, input int n);
      return dw + cw + $clog2(n);
   endfunction

   // The accumulator arrives sign-extended to SAT_W; the result is clamped to a dw-bit signed range.
   function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                         input int frac, input int dw);
      logic signed [SAT_W-1:0] one, r, max_v, min_v;
      one   = {{(SAT_W-1){1'b0}}, 1'b1};
      r     = (acc + (one <<< (frac - 1))) >>> frac;
      max_v = (one <<< (dw - 1)) - one;
      min_v = -(one <<< (dw - 1));
      if (r > max_v) begin
         r = max_v;
      end else if (r < min_v) begin
         r = min_v;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_tdm_mac_filter_tap_store.sv
// rtl/fir_tdm_mac_filter_tap_store.sv - per-channel circular delay lines, write pointers and coefficient file
module fir_tap_store
   import fir_pkg::*;
#(
   parameter int              DW        = 24,
   parameter int              CW        = 12,
   parameter int              N         = 31,
   parameter int              NCH       = 2,
   parameter int              CHW       = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int              KW        = $clog2(N),
   parameter logic [N*CW-1:0] COEF_INIT = '0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           s_we_i,
   input  logic [CHW-1:0] s_wch_i,
   input  logic [DW-1:0]  s_wdata_i,
   output logic [KW-1:0]  s_ptr_o,
   input  logic [CHW-1:0] s_rch_i,
   input  logic [KW-1:0]  s_raddr_i,
   output logic [DW-1:0]  s_rdata_o,
   input  logic           c_we_i,
   input  logic [KW-1:0]  c_waddr_i,
   input  logic [CW-1:0]  c_wdata_i,
   input  logic [KW-1:0]  c_raddr_i,
   output logic [CW-1:0]  c_rdata_o
);

   logic [DW-1:0] dl_q   [NCH][N];
   logic [KW-1:0] ptr_q  [NCH];
   logic [CW-1:0] coef_q [N];

   assign s_ptr_o   = ptr_q[s_wch_i];
   assign s_rdata_o = dl_q[s_rch_i][s_raddr_i];
   assign c_rdata_o = coef_q[c_raddr_i];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < NCH; c++) begin
            ptr_q[c] <= '0;
            for (int k = 0; k < N; k++) begin
               dl_q[c][k] <= '0;
            end
         end
         for (int k = 0; k < N; k++) begin
            coef_q[k] <= COEF_INIT[k*CW +: CW];
         end
      end else begin
         // The write pointer ends up one past the newest sample, wrapping at N.
         if (s_we_i) begin
            dl_q[s_wch_i][ptr_q[s_wch_i]] <= s_wdata_i;
            ptr_q[s_wch_i] <= (ptr_q[s_wch_i] == KW'(N - 1)) ? '0 : ptr_q[s_wch_i] + 1'b1;
         end
         if (c_we_i) begin
            coef_q[c_waddr_i] <= c_wdata_i;
         end
      end
   end

endmodule

// File: rtl/fir_tdm_mac_filter.sv
// rtl/fir_tdm_mac_filter.sv - multi-channel TDM FIR: one tap per clock, rounded and saturated output
module fir_tdm_mac_filter
   import fir_pkg::*;
#(
   parameter int              DW        = 24,
   parameter int              CW        = 12,
   parameter int              N         = 31,
   parameter int              NCH       = 2,
   parameter int              FRAC      = 11,
   parameter logic [N*CW-1:0] COEF_INIT = '0,
   localparam int             CHW       = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int             KW        = $clog2(N)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           enable_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [DW-1:0]  in_data_i,
   input  logic [CHW-1:0] in_ch_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [DW-1:0]  out_data_o,
   output logic [CHW-1:0] out_ch_o,
   input  logic           coef_we_i,
   input  logic [KW-1:0]  coef_addr_i,
   input  logic [CW-1:0]  coef_wdata_i,
   output logic           coef_ready_o
);

   localparam int AW = fir_acc_w(DW, CW, N);
   localparam int PW = DW + CW;

   fir_state_e            state_q, state_d;
   logic [KW-1:0]         k_q, k_d, base_q, base_d;
   logic [CHW-1:0]        ch_q, ch_d, out_ch_q, out_ch_d;
   logic                  byp_q, byp_d, out_valid_q, out_valid_d;
   logic [DW-1:0]         samp_q, samp_d, out_data_q, out_data_d;
   logic signed [AW-1:0]  acc_q, acc_d;

   logic                  accept, ch_ok;
   logic [KW-1:0]         s_ptr, rd_idx;
   logic [DW-1:0]         s_rdata;
   logic [CW-1:0]         c_rdata;
   logic signed [PW-1:0]  s_ext, c_ext, prod;
   logic [DW-1:0]         result;

   assign in_ready_o   = (state_q == IDLE) && !rst_i;
   assign coef_ready_o = (state_q == IDLE);
   assign accept       = in_valid_i && in_ready_o;
   assign ch_ok        = int'(in_ch_i) < NCH;

   // Newest sample is tap 0; modulo-2^KW arithmetic lands on the right slot once N is added back.
   assign rd_idx = (base_q >= k_q) ? base_q - k_q : base_q - k_q + KW'(N);
   assign s_ext  = PW'($signed(s_rdata));
   assign c_ext  = PW'($signed(c_rdata));
   assign prod   = s_ext * c_ext;
   assign result = byp_q ? samp_q : DW'(sat_round(SAT_W'(acc_q), FRAC, DW));

   fir_tap_store #(
      .DW(DW), .CW(CW), .N(N), .NCH(NCH), .CHW(CHW), .KW(KW), .COEF_INIT(COEF_INIT)
   ) u_store (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .s_we_i    (accept && ch_ok),
      .s_wch_i   (in_ch_i),
      .s_wdata_i (in_data_i),
      .s_ptr_o   (s_ptr),
      .s_rch_i   (ch_q),
      .s_raddr_i (rd_idx),
      .s_rdata_o (s_rdata),
      .c_we_i    (coef_we_i && coef_ready_o),
      .c_waddr_i (coef_addr_i),
      .c_wdata_i (coef_wdata_i),
      .c_raddr_i (k_q),
      .c_rdata_o (c_rdata)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      base_d      = base_q;
      ch_d        = ch_q;
      byp_d       = byp_q;
      samp_d      = samp_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (accept && ch_ok) begin
               base_d  = s_ptr;
               ch_d    = in_ch_i;
               byp_d   = !enable_i;
               samp_d  = in_data_i;
               acc_d   = '0;
               k_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + AW'(prod);
            if (k_q == KW'(N - 1)) begin
               state_d = ROUND;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ROUND: begin
            out_data_d  = result;
            out_ch_d    = ch_q;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         k_q         <= '0;
         base_q      <= '0;
         ch_q        <= '0;
         byp_q       <= 1'b0;
         samp_q      <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         base_q      <= base_d;
         ch_q        <= ch_d;
         byp_q       <= byp_d;
         samp_q      <= samp_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_fir_tdm_mac_filter.sv
// tb/tb_fir_tdm_mac_filter.sv - scoreboard bench for the TDM serial-MAC FIR
module tb_fir_tdm_mac_filter;

   // CW=13 so that 2048 (unity gain with FRAC=11) is a positive coefficient; NCH=3 leaves code 3 invalid.
   localparam int DW = 24, CW = 13, N = 31, NCH = 3, FRAC = 11, CHW = 2, KW = 5;
   localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (DW - 1));

   function automatic logic [N*CW-1:0] init_coefs();
      logic [N*CW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*CW +: CW] = CW'(k + 1);
      return v;
   endfunction
   localparam logic [N*CW-1:0] CI = init_coefs();

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [DW-1:0]  in_data = '0;
   logic [CHW-1:0] in_ch = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [DW-1:0]  out_data;
   logic [CHW-1:0] out_ch;
   logic           coef_we = 1'b0;
   logic [KW-1:0]  coef_addr = '0;
   logic [CW-1:0]  coef_wdata = '0;
   logic           coef_ready;

   fir_tdm_mac_filter #(
      .DW(DW), .CW(CW), .N(N), .NCH(NCH), .FRAC(FRAC), .COEF_INIT(CI)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_ch_i(in_ch),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_ch_o(out_ch),
      .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata), .coef_ready_o(coef_ready)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [DW-1:0]  d;
      logic [CHW-1:0] c;
   } exp_t;
   exp_t sb[$];

   logic signed [DW-1:0] m_dl [NCH][N];
   logic signed [CW-1:0] m_coef [N];
   int                   m_ptr [NCH];

   function automatic void model_reset();
      logic [N*CW-1:0] ci_v;
      ci_v = CI;
      for (int c = 0; c < NCH; c++) begin
         m_ptr[c] = 0;
         for (int k = 0; k < N; k++) m_dl[c][k] = '0;
      end
      for (int k = 0; k < N; k++) m_coef[k] = $signed(ci_v[k*CW +: CW]);
   endfunction

   function automatic logic [DW-1:0] model_push(input int ch, input logic [DW-1:0] d, input logic en);
      longint acc, r;
      int idx;
      m_dl[ch][m_ptr[ch]] = $signed(d);
      acc = 0;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr[ch] - k + N) % N;
         acc += longint'(m_dl[ch][idx]) * longint'(m_coef[k]);
      end
      m_ptr[ch] = (m_ptr[ch] + 1) % N;
      r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
      return en ? r[DW-1:0] : d;
   endfunction

   function automatic exp_t sb_pop();
      exp_t e;
      e.d = 'x;
      e.c = 'x;
      if (sb.size() != 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic drive(input int ch, input logic [DW-1:0] d, input logic en,
                        output longint acc_edge, output bit to);
      int n;
      in_ch = CHW'(ch); in_data = d; enable = en; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      to = !in_ready;
      acc_edge = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0; enable = 1'b1;
      if (!to && ch < NCH) sb.push_back('{d: model_push(ch, d, en), c: CHW'(ch)});
   endtask

   task automatic wait_out(output logic [DW-1:0] d, output logic [CHW-1:0] c,
                           output longint e, output bit to);
      int n;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      to = !out_valid; e = cyc; d = out_data; c = out_ch;
      if (out_ready && !to) begin @(posedge clk); #1; end
   endtask

   task automatic run_sample(input int ch, input logic [DW-1:0] d, input logic en,
                             output logic [DW-1:0] od, output logic [CHW-1:0] oc, output bit to);
      longint a, e;
      bit t1, t2;
      drive(ch, d, en, a, t1);
      wait_out(od, oc, e, t2);
      to = t1 | t2;
   endtask

   task automatic write_coef(input int a, input logic [CW-1:0] v);
      int n;
      coef_we = 1'b1; coef_addr = KW'(a); coef_wdata = v;
      n = 0;
      while (!coef_ready && n < 200) begin @(negedge clk); n++; end
      if (!coef_ready) begin
         checks++; errors++;
         $display("FAIL coef_write_timeout addr=%0d coef_ready=%0b expected 1", a, coef_ready);
      end else begin
         m_coef[a] = $signed(v);
      end
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h expected=0", out_data); end
      checks++; if (out_ch !== '0) begin errors++; $display("FAIL reset_out_ch got=%0d expected=0", out_ch); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_in_rst got=%b expected=0", in_ready); end
      checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL reset_coef_ready got=%b expected=1", coef_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b expected=1", in_ready); end
      model_reset();
   endtask

   task automatic test_impulse();
      logic [DW-1:0] od; logic [CHW-1:0] oc; bit to; exp_t e;
      for (int i = 0; i < 32; i++) begin
         run_sample(0, (i == 0) ? DW'(2048) : '0, 1'b1, od, oc, to);
         e = sb_pop();
         checks++;
         if (to || od !== e.d || oc !== e.c) begin
            errors++; $display("FAIL impulse_model[%0d] got=%h ch=%0d expected=%h ch=%0d to=%0b", i, od, oc, e.d, e.c, to);
         end
         checks++;
         if (od !== ((i < 31) ? DW'(i + 1) : DW'(0))) begin
            errors++; $display("FAIL impulse_const[%0d] got=%0d expected=%0d", i, od, (i < 31) ? i + 1 : 0);
         end
      end
   endtask

   task automatic test_channel_isolation();
      logic [DW-1:0] od; logic [CHW-1:0] oc; bit to; exp_t e;
      for (int k = 0; k < N; k++) write_coef(k, CW'(2048));
      for (int i = 0; i < 32; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            run_sample(ch, (ch == 1) ? DW'(1000) : ((i == 0) ? DW'(2048) : '0), 1'b1, od, oc, to);
            e = sb_pop();
            checks++;
            if (to || od !== e.d || oc !== e.c) begin
               errors++; $display("FAIL iso_model[%0d] ch=%0d got=%0d/%0d expected=%0d/%0d to=%0b", i, ch, od, oc, e.d, e.c, to);
            end
            if (ch == 0) begin
               checks++;
               if (od !== ((i < 31) ? DW'(2048) : DW'(0))) begin
                  errors++; $display("FAIL iso_ch0[%0d] got=%0d expected=%0d", i, od, (i < 31) ? 2048 : 0);
               end
            end else if (i >= 30) begin
               checks++;
               if (od !== DW'(31000)) begin errors++; $display("FAIL iso_ch1_steady[%0d] got=%0d expected=31000", i, od); end
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic [DW-1:0] od; logic [CHW-1:0] oc; bit to; exp_t e;
      logic [DW-1:0] pat [2];
      pat[0] = 24'h7FFFFF; pat[1] = 24'h800000;
      for (int k = 0; k < N; k++) write_coef(k, CW'(2047));
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < N; i++) begin
            run_sample(2, pat[p], 1'b1, od, oc, to);
            e = sb_pop();
            checks++;
            if (to || od !== e.d || oc !== e.c) begin
               errors++; $display("FAIL sat_model[%0d][%0d] got=%h expected=%h to=%0b", p, i, od, e.d, to);
            end
         end
         checks++;
         if (od !== pat[p]) begin errors++; $display("FAIL sat_clip[%0d] got=%h expected=%h", p, od, pat[p]); end
      end
      write_coef(0, CW'(1024));
      for (int k = 1; k < N; k++) write_coef(k, '0);
      run_sample(1, DW'(3), 1'b1, od, oc, to);
      e = sb_pop();
      checks++; if (to || od !== e.d) begin errors++; $display("FAIL round_pos_model got=%0d expected=%0d", od, e.d); end
      checks++; if (od !== DW'(2)) begin errors++; $display("FAIL round_pos got=%0d expected=2", od); end
      run_sample(1, 24'hFFFFFD, 1'b1, od, oc, to);
      e = sb_pop();
      checks++; if (to || od !== e.d) begin errors++; $display("FAIL round_neg_model got=%h expected=%h", od, e.d); end
      checks++; if (od !== 24'hFFFFFF) begin errors++; $display("FAIL round_neg got=%h expected=ffffff", od); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] od, od2; logic [CHW-1:0] oc; bit t1, t2; exp_t e; longint a, a2, ev;
      out_ready = 1'b0;
      drive(0, DW'(5), 1'b1, a, t1);
      wait_out(od, oc, ev, t2);
      checks++;
      if (t1 || t2 || ev - a != longint'(N + 1)) begin
         errors++; $display("FAIL latency got=%0d expected=%0d to=%0b", ev - a, N + 1, t1 | t2);
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== od || in_ready !== 1'b0 || coef_ready !== 1'b0) begin
            errors++; $display("FAIL hold[%0d] valid=%b data=%h in_ready=%b expected 1/%h/0", i, out_valid, out_data, in_ready, od);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL release valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      e = sb_pop();
      checks++; if (od !== e.d || od !== DW'(3)) begin errors++; $display("FAIL bp_data got=%0d expected=%0d", od, e.d); end
      drive(1, DW'(40), 1'b1, a, t1);
      wait_out(od, oc, ev, t2);
      drive(2, DW'(-40), 1'b1, a2, t1);
      wait_out(od2, oc, ev, t2);
      checks++;
      if (a2 - a != longint'(N + 3)) begin errors++; $display("FAIL throughput got=%0d expected=%0d", a2 - a, N + 3); end
      e = sb_pop();
      checks++; if (od !== e.d) begin errors++; $display("FAIL tput_a got=%0d expected=%0d", od, e.d); end
      e = sb_pop();
      checks++; if (od2 !== e.d || oc !== e.c) begin errors++; $display("FAIL tput_b got=%h expected=%h", od2, e.d); end
   endtask

   task automatic test_bypass_coef();
      logic [DW-1:0] od; logic [CHW-1:0] oc; bit to, t1, t2; exp_t e; longint a, ev;
      run_sample(2, 24'h123456, 1'b0, od, oc, to);
      e = sb_pop();
      checks++; if (to || od !== 24'h123456 || od !== e.d || oc !== 2'd2) begin errors++; $display("FAIL bypass got=%h expected=123456", od); end
      drive(1, DW'(100), 1'b1, a, t1);
      coef_we = 1'b1; coef_addr = '0; coef_wdata = CW'(512);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL busy_coef_ready got=%b expected=0", coef_ready); end
      end
      coef_we = 1'b0;
      wait_out(od, oc, ev, t2);
      for (int j = 0; j < 2; j++) begin
         if (j == 1) run_sample(1, DW'(100), 1'b1, od, oc, t2);
         e = sb_pop();
         checks++;
         if (t1 || t2 || od !== e.d || od !== DW'(50)) begin errors++; $display("FAIL busy_write_ignored[%0d] got=%0d expected=50", j, od); end
      end
      write_coef(0, CW'(2047));
      run_sample(1, DW'(100), 1'b1, od, oc, to);
      e = sb_pop();
      checks++; if (to || od !== e.d || od !== DW'(100)) begin errors++; $display("FAIL idle_write got=%0d expected=100", od); end
      coef_we = 1'b1; coef_addr = '0; coef_wdata = CW'(512);
      m_coef[0] = CW'(512);
      drive(1, DW'(100), 1'b1, a, t1);
      coef_we = 1'b0;
      wait_out(od, oc, ev, t2);
      e = sb_pop();
      checks++; if (t1 || t2 || od !== e.d || od !== DW'(25)) begin errors++; $display("FAIL simul_write got=%0d expected=25", od); end
      drive(3, DW'(777), 1'b1, a, t1);
      checks++; if (t1) begin errors++; $display("FAIL invalid_ch_handshake accepted=0 expected=1"); end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL invalid_ch[%0d] valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [DW-1:0] od; logic [CHW-1:0] oc; bit to, t1; exp_t e; longint a, ev;
      out_ready = 1'b0;
      run_sample(0, DW'(7777), 1'b1, od, oc, to);
      e = sb_pop();
      checks++; if (to || od !== e.d) begin errors++; $display("FAIL pre_reset got=%0d expected=%0d", od, e.d); end
      rst = 1'b1; #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
         errors++; $display("FAIL reset_in_out valid=%b data=%h ch=%0d expected 0/0/0", out_valid, out_data, out_ch);
      end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      model_reset(); sb.delete();
      drive(0, DW'(4096), 1'b1, a, t1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1; #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || coef_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_mac valid=%b in_ready=%b coef_ready=%b expected 0/0/1", out_valid, in_ready, coef_ready);
      end
      @(negedge clk); rst = 1'b0;
      model_reset(); sb.delete();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_output[%0d] valid=%b expected=0", i, out_valid); end
      end
      for (int i = 0; i < 7; i++) begin
         run_sample(0, (i == 0) ? DW'(2048) : '0, 1'b1, od, oc, to);
         e = sb_pop();
         checks++;
         if (to || od !== e.d || od !== DW'(i + 1)) begin
            errors++; $display("FAIL post_reset_impulse[%0d] got=%0d expected=%0d model=%0d", i, od, i + 1, e.d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_channel_isolation();
      test_saturation();
      test_backpressure();
      test_bypass_coef();
      test_reset_mid_mac();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout cycles=%0d", cyc);
      $fatal(1);
   end

endmodule
